// File: rtl/imm_pkg.sv
// Shared constants and entry type for the LEGv8 immediate generator.
// Field positions are taken relative to the 26-bit instruction field Imm26.
package imm_pkg;

   localparam int MAX_W = 64;

   localparam logic [2:0] CTRL_I    = 3'b000;
   localparam logic [2:0] CTRL_D    = 3'b001;
   localparam logic [2:0] CTRL_B    = 3'b010;
   localparam logic [2:0] CTRL_CB   = 3'b011;
   localparam logic [2:0] CTRL_MOVZ = 3'b100;
   localparam logic [2:0] CTRL_MOVK = 3'b101;

   localparam int I_LSB   = 10;
   localparam int I_W     = 12;
   localparam int D_LSB   = 12;
   localparam int D_W     = 9;
   localparam int B_W     = 26;
   localparam int CB_LSB  = 5;
   localparam int CB_W    = 19;
   localparam int MOV_LSB = 5;
   localparam int MOV_W   = 16;
   localparam int HW_LSB  = 21;

   // Data is held at the widest legal size; narrower builds leave the top bits zero.
   typedef struct packed {
      logic [MAX_W-1:0] data;
      logic             illegal;
   } imm_entry_t;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter: builds the result at 64 bits, then
// truncates to DATA_W. Illegal encodings force the data to zero.
module imm_format
   import imm_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int BR_SHIFT = 0
) (
   input  logic [25:0]       Imm26,
   input  logic [2:0]        Ctrl,
   input  logic [DATA_W-1:0] BusOld,
   output logic [DATA_W-1:0] data,
   output logic              illegal
);

   logic [1:0]       hw;
   logic [5:0]       sh;
   logic             hw_oob;
   logic [MAX_W-1:0] mov_ext;
   logic [MAX_W-1:0] old_ext;
   logic [MAX_W-1:0] ext;

   assign hw      = Imm26[HW_LSB +: 2];
   assign sh      = {hw, 4'b0000};
   // Only the 32-bit build can place a halfword beyond the top of the bus.
   assign hw_oob  = (DATA_W < MAX_W) && hw[1];
   assign mov_ext = {{(MAX_W-MOV_W){1'b0}}, Imm26[MOV_LSB +: MOV_W]};

   always_comb begin
      old_ext = '0;
      old_ext[DATA_W-1:0] = BusOld;
      ext     = '0;
      illegal = 1'b0;
      case (Ctrl)
         CTRL_I:  ext = {{(MAX_W-I_W){1'b0}}, Imm26[I_LSB +: I_W]};
         CTRL_D:  ext = {{(MAX_W-D_W){Imm26[D_LSB+D_W-1]}}, Imm26[D_LSB +: D_W]};
         CTRL_B: begin
            ext = {{(MAX_W-B_W){Imm26[B_W-1]}}, Imm26};
            if (BR_SHIFT != 0) ext = ext << 2;
         end
         CTRL_CB: begin
            ext = {{(MAX_W-CB_W){Imm26[CB_LSB+CB_W-1]}}, Imm26[CB_LSB +: CB_W]};
            if (BR_SHIFT != 0) ext = ext << 2;
         end
         CTRL_MOVZ: begin
            ext     = mov_ext << sh;
            illegal = hw_oob;
         end
         CTRL_MOVK: begin
            ext     = (old_ext & ~({{(MAX_W-MOV_W){1'b0}}, {MOV_W{1'b1}}} << sh)) | (mov_ext << sh);
            illegal = hw_oob;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign data = illegal ? '0 : ext[DATA_W-1:0];

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: formatter feeding a head register plus a
// one-entry skid buffer, with a saturating illegal-request counter.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int BR_SHIFT = 0,
   parameter int CNT_W    = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [25:0]       Imm26,
   input  logic [2:0]        Ctrl,
   input  logic [DATA_W-1:0] BusOld,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] BusImm,
   output logic              IllegalFmt,
   output logic [CNT_W-1:0]  IllegalCount
);

   logic [DATA_W-1:0] fmt_data;
   logic              fmt_illegal;
   imm_entry_t        new_entry;

   imm_entry_t        head_q, head_d;
   logic              head_vld_q, head_vld_d;
   imm_entry_t        skid_q, skid_d;
   logic              skid_vld_q, skid_vld_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              drain;

   imm_format #(
      .DATA_W   (DATA_W),
      .BR_SHIFT (BR_SHIFT)
   ) u_fmt (
      .Imm26   (Imm26),
      .Ctrl    (Ctrl),
      .BusOld  (BusOld),
      .data    (fmt_data),
      .illegal (fmt_illegal)
   );

   always_comb begin
      new_entry         = '0;
      new_entry.data[DATA_W-1:0] = fmt_data;
      new_entry.illegal = fmt_illegal;
   end

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; the producer holds its payload stable while valid && !ready.
   assign accept = InValid && in_ready_q;
   assign drain  = head_vld_q && OutReady;

   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      cnt_d      = cnt_q;
      if (drain || !head_vld_q) begin
         if (skid_vld_q) begin
            head_d     = skid_q;
            head_vld_d = 1'b1;
            skid_vld_d = accept;
            if (accept) skid_d = new_entry;
         end else begin
            head_vld_d = accept;
            if (accept) head_d = new_entry;
         end
      end else if (accept) begin
         skid_d     = new_entry;
         skid_vld_d = 1'b1;
      end
      if (accept && fmt_illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
      in_ready_d = !skid_vld_d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         head_q     <= '0;
         head_vld_q <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign InReady      = in_ready_q;
   assign OutValid     = head_vld_q;
   assign BusImm       = head_q.data[DATA_W-1:0];
   assign IllegalFmt   = head_q.illegal;
   assign IllegalCount = cnt_q;

endmodule
